// File: rtl/pll_reset_seq_pkg.sv
// Shared types and counter sizing helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_FILTER,
    ST_STAGGER_WAIT,
    ST_RUN
  } chan_state_t;

  localparam int unsigned LOL_CNT_W = 8;

  // Bits needed to hold every value in 0..top.
  function automatic int unsigned cnt_w(input int unsigned top);
    return (top < 2) ? 1 : $clog2(top + 1);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_chan_fsm.sv
// One PLL channel: reset pulse, lock wait with timeout, lock filter, stagger hold, run.
// Optional loss-of-lock counter under PLL_RESET_SEQ_LOL_COUNT_EN.
module pll_chan_fsm
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 release_ok,
  input  logic                 up_run,
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
  input  logic                 clear_counts,
  output logic [LOL_CNT_W-1:0] lol_count,
`endif
  output logic                 pll_rst,
  output logic                 ch_reset_n,
  output logic                 in_run,
  output logic                 retry_err
);

  localparam int unsigned CNT_TOP = umax(umax(PLL_RST_CYCLES, LOCK_FILTER), LOCK_TIMEOUT) - 1;
  localparam int unsigned CW      = cnt_w(CNT_TOP);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);

  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          set_err;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign in_run  = (state_q == ST_RUN);

  // A low sample while filtering only restarts the lock wait; the PLL is not re-reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_err = 1'b0;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q >= RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked) begin
          state_d = ST_FILTER;
          cnt_d   = '0;
        end else if (cnt_q >= TMO_LAST) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FILTER: begin
        if (!locked) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= FLT_LAST) begin
          state_d = ST_STAGGER_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STAGGER_WAIT: begin
        cnt_d = '0;
        if (!locked)          state_d = ST_PLL_RST;
        else if (release_ok)  state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked)       state_d = ST_PLL_RST;
        else if (!up_run)  state_d = ST_STAGGER_WAIT;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      pll_rst    <= 1'b1;
      ch_reset_n <= 1'b0;
      retry_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rst    <= (state_d == ST_PLL_RST);
      ch_reset_n <= (state_q == ST_RUN) && (state_d == ST_RUN);
      retry_err  <= retry_err | set_err;
    end
  end

`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
  logic lol_exit;
  assign lol_exit = (state_q == ST_RUN) && !locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lol_count <= '0;
    end else if (clear_counts) begin
      lol_count <= '0;
    end else if (lol_exit && (lol_count != '1)) begin
      lol_count <= lol_count + LOL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/pll_reset_seq.sv
// Multi-PLL reset sequencer: lock synchronisers, staggered channel release, all_ready.
// Define PLL_RESET_SEQ_LOL_COUNT_EN to add per-channel loss-of-lock counters.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned NUM_PLL        = 2,
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STAGGER        = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PLL-1:0]             pll_locked,
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
  input  logic                           clear_counts,
  output logic [NUM_PLL*LOL_CNT_W-1:0]   lol_count,
`endif
  output logic [NUM_PLL-1:0]             pll_rst,
  output logic [NUM_PLL-1:0]             ch_reset_n,
  output logic                           all_ready,
  output logic [NUM_PLL-1:0]             retry_err
);

  localparam int unsigned SW = cnt_w(STAGGER);
  localparam logic [SW-1:0] STAG_MAX = SW'(STAGGER);
  // Release one cycle early so the registered state change lands exactly STAGGER cycles later.
  localparam logic [SW-1:0] REL_AT   = SW'((STAGGER == 0) ? 0 : STAGGER - 1);

  logic [NUM_PLL-1:0] sync1, sync2;
  logic [NUM_PLL-1:0] in_run, release_ok, up_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
    if (i == 0) begin : g_first
      assign release_ok[i] = 1'b1;
      assign up_run[i]     = 1'b1;
    end else begin : g_next
      logic [SW-1:0] run_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 run_cnt <= '0;
        else if (!in_run[i-1])        run_cnt <= '0;
        else if (run_cnt != STAG_MAX) run_cnt <= run_cnt + SW'(1);
      end

      assign release_ok[i] = in_run[i-1] && (run_cnt >= REL_AT);
      assign up_run[i]     = in_run[i-1];
    end

    pll_chan_fsm #(
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_FILTER    (LOCK_FILTER),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .locked       (sync2[i]),
      .release_ok   (release_ok[i]),
      .up_run       (up_run[i]),
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
      .clear_counts (clear_counts),
      .lol_count    (lol_count[i*LOL_CNT_W +: LOL_CNT_W]),
`endif
      .pll_rst      (pll_rst[i]),
      .ch_reset_n   (ch_reset_n[i]),
      .in_run       (in_run[i]),
      .retry_err    (retry_err[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) all_ready <= 1'b0;
    else          all_ready <= &in_run;
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short timing parameters.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pll_locked = 2'b00;
  logic [1:0] pll_rst, ch_reset_n, retry_err;
  logic       all_ready;
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
  logic        clear_counts = 1'b0;
  logic [15:0] lol_count;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .NUM_PLL        (2),
    .PLL_RST_CYCLES (2),
    .LOCK_FILTER    (4),
    .LOCK_TIMEOUT   (20),
    .STAGGER        (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
    .clear_counts (clear_counts),
    .lol_count    (lol_count),
`endif
    .pll_rst      (pll_rst),
    .ch_reset_n   (ch_reset_n),
    .all_ready    (all_ready),
    .retry_err    (retry_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset with the given raw lock levels, check reset outputs, release at a negedge.
  task automatic do_reset(input logic [1:0] lk);
    reset_n    = 1'b0;
    pll_locked = lk;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_pll_rst", 32'(pll_rst), 32'h3);
    check_eq("rst_ch_reset_n", 32'(ch_reset_n), 32'h0);
    check_eq("rst_all_ready", 32'(all_ready), 32'h0);
    check_eq("rst_retry_err", 32'(retry_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Normal bring-up, then loss of lock on channel 0 while both run.
    do_reset(2'b11);
    step(1);  check_eq("up_pll_rst_e1", 32'(pll_rst), 32'h3);
    step(1);  check_eq("up_pll_rst_e2", 32'(pll_rst), 32'h0);
    step(6);  check_eq("up_chrst_e8", 32'(ch_reset_n), 32'h0);
    step(1);  check_eq("up_chrst_e9", 32'(ch_reset_n), 32'h1);
              check_eq("up_ready_e9", 32'(all_ready), 32'h0);
    step(2);  check_eq("up_chrst_e11", 32'(ch_reset_n), 32'h1);
    step(1);  check_eq("up_chrst_e12", 32'(ch_reset_n), 32'h3);
              check_eq("up_ready_e12", 32'(all_ready), 32'h1);
    step(2);
    pll_locked = 2'b10;
    step(2);  check_eq("lol_chrst_k2", 32'(ch_reset_n), 32'h3);
              check_eq("lol_pll_rst_k2", 32'(pll_rst), 32'h0);
    step(1);  check_eq("lol_chrst_k3", 32'(ch_reset_n), 32'h2);
              check_eq("lol_pll_rst_k3", 32'(pll_rst), 32'h1);
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
              check_eq("lol_count_k3", 32'(lol_count), 32'h0001);
`endif
    step(1);  check_eq("lol_chrst_k4", 32'(ch_reset_n), 32'h0);
              check_eq("lol_pll_rst_k4", 32'(pll_rst), 32'h1);
              check_eq("lol_ready_k4", 32'(all_ready), 32'h0);
    step(1);  check_eq("lol_pll_rst_k5", 32'(pll_rst), 32'h0);
              check_eq("lol_retry_k5", 32'(retry_err), 32'h0);
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
    clear_counts = 1'b1;
    step(1);
    clear_counts = 1'b0;
    check_eq("lol_count_clr", 32'(lol_count), 32'h0000);
`endif

    // One-cycle glitch on channel 0 lock while it filters.
    do_reset(2'b11);
    step(2);
    pll_locked = 2'b10;
    step(1);
    pll_locked = 2'b11;
    step(8);  check_eq("gl_chrst_e11", 32'(ch_reset_n), 32'h0);
    step(1);  check_eq("gl_chrst_e12", 32'(ch_reset_n), 32'h1);
    step(2);  check_eq("gl_chrst_e14", 32'(ch_reset_n), 32'h1);
    step(1);  check_eq("gl_chrst_e15", 32'(ch_reset_n), 32'h3);
              check_eq("gl_ready_e15", 32'(all_ready), 32'h1);

    // Channel 1 never locks: timeout, retry pulse, repeat.
    do_reset(2'b01);
    step(21); check_eq("to_retry_e21", 32'(retry_err), 32'h0);
              check_eq("to_pll_rst_e21", 32'(pll_rst), 32'h0);
    step(1);  check_eq("to_retry_e22", 32'(retry_err), 32'h2);
              check_eq("to_pll_rst_e22", 32'(pll_rst), 32'h2);
    step(1);  check_eq("to_pll_rst_e23", 32'(pll_rst), 32'h2);
    step(1);  check_eq("to_pll_rst_e24", 32'(pll_rst), 32'h0);
              check_eq("to_chrst_e24", 32'(ch_reset_n), 32'h1);
              check_eq("to_ready_e24", 32'(all_ready), 32'h0);
    step(19); check_eq("to_pll_rst_e43", 32'(pll_rst), 32'h0);
    step(1);  check_eq("to_pll_rst_e44", 32'(pll_rst), 32'h2);
              check_eq("to_retry_e44", 32'(retry_err), 32'h2);

    // Asynchronous reset while channel 1 waits on the stagger.
    do_reset(2'b11);
    step(9);  check_eq("ar_chrst_e9", 32'(ch_reset_n), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_pll_rst", 32'(pll_rst), 32'h3);
    check_eq("ar_chrst", 32'(ch_reset_n), 32'h0);
    check_eq("ar_ready", 32'(all_ready), 32'h0);
    check_eq("ar_retry", 32'(retry_err), 32'h0);
`ifdef PLL_RESET_SEQ_LOL_COUNT_EN
    check_eq("ar_lol_count", 32'(lol_count), 32'h0000);
`endif
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
